// File: rtl/mult_div_unit_pkg.sv
// Shared multiply/divide definitions: mdop encoding, default latencies,
// sequencer state and commit kinds. Used by the decoder and hazard unit too.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MDOP_NONE  = 4'b0000,
    MDOP_MULT  = 4'b0001,
    MDOP_MULTU = 4'b0010,
    MDOP_DIV   = 4'b0011,
    MDOP_DIVU  = 4'b0100,
    MDOP_MTHI  = 4'b0101,
    MDOP_MTLO  = 4'b0110,
    MDOP_MADD  = 4'b1000,
    MDOP_MADDU = 4'b1001,
    MDOP_MSUB  = 4'b1010,
    MDOP_MSUBU = 4'b1011
  } mdop_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } mdu_state_e;

  // What happens to HI/LO when a running operation finishes.
  typedef enum logic [1:0] {
    CM_WRITE,
    CM_KEEP,
    CM_ADD,
    CM_SUB
  } commit_e;

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == MDOP_MULT) || (op == MDOP_DIV) ||
           (op == MDOP_MADD) || (op == MDOP_MSUB);
  endfunction

endpackage

// File: rtl/mult_div_unit_calc.sv
// mdu_calc: combinational 64-bit result for the current mdop/a/b.
// Multiply classes give the product; div/divu give {remainder, quotient}.
module mdu_calc
  import mult_div_unit_pkg::*;
(
  input  logic [3:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic        sgn;
  logic        is_div;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] q;
  logic [31:0] r;

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps to
  // 0x80000000 instead of overflowing; divisor forced to 1 on b==0.
  always_comb begin
    sgn     = op_is_signed(mdop);
    is_div  = (mdop == MDOP_DIV) || (mdop == MDOP_DIVU);
    ext_a   = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    ext_b   = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    prod    = ext_a * ext_b;
    neg_a   = sgn && a[31];
    neg_b   = sgn && b[31];
    mag_a   = neg_a ? (~a + 32'd1) : a;
    mag_b   = neg_b ? (~b + 32'd1) : b;
    divisor = (b == '0) ? 32'd1 : mag_b;
    uq      = mag_a / divisor;
    ur      = mag_a % divisor;
    q       = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    r       = neg_a ? (~ur + 32'd1) : ur;
    result  = is_div ? {r, q} : prod;
    div_by_zero = (b == '0);
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit owning HI/LO.
// Optional multiply-accumulate ops are built only with `define MDU_MADD_EN.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [3:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      shadow_q, shadow_d;
  commit_e          commit_q, commit_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0] calc_result;
  logic        calc_dbz;
  logic        accept;

  mdu_calc u_calc (
    .mdop        (mdop),
    .a           (a),
    .b           (b),
    .result      (calc_result),
    .div_by_zero (calc_dbz)
  );

  assign accept = start && !flush && (state_q == ST_IDLE);
  assign busy   = (state_q == ST_RUN);
  assign hi     = hi_q;
  assign lo     = lo_q;

  // Sequencer: launch on accept, count down in RUN, commit shadow at count 1.
  // A flush during RUN has no effect; the op has already retired past EX.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    commit_d = commit_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (mdop_e'(mdop))
            MDOP_MULT, MDOP_MULTU: begin
              state_d  = ST_RUN;
              cnt_d    = MULT_LOAD;
              shadow_d = calc_result;
              commit_d = CM_WRITE;
            end
            MDOP_DIV, MDOP_DIVU: begin
              state_d  = ST_RUN;
              cnt_d    = DIV_LOAD;
              shadow_d = calc_result;
              commit_d = calc_dbz ? CM_KEEP : CM_WRITE;
            end
            MDOP_MTHI: hi_d = a;
            MDOP_MTLO: lo_d = a;
`ifdef MDU_MADD_EN
            MDOP_MADD, MDOP_MADDU: begin
              state_d  = ST_RUN;
              cnt_d    = MULT_LOAD;
              shadow_d = calc_result;
              commit_d = CM_ADD;
            end
            MDOP_MSUB, MDOP_MSUBU: begin
              state_d  = ST_RUN;
              cnt_d    = MULT_LOAD;
              shadow_d = calc_result;
              commit_d = CM_SUB;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          case (commit_q)
            CM_WRITE: {hi_d, lo_d} = shadow_q;
`ifdef MDU_MADD_EN
            // Accumulates against HI/LO as they stand at commit time.
            CM_ADD:   {hi_d, lo_d} = {hi_q, lo_q} + shadow_q;
            CM_SUB:   {hi_d, lo_d} = {hi_q, lo_q} - shadow_q;
`endif
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, shadow and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      commit_q <= CM_WRITE;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      commit_q <= commit_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule
